// File: rtl/scan_angle_sequencer_if.sv
// Beam output bus from scan_angle_sequencer to the ray tracer (valid/ready handshake).
interface scan_angle_sequencer_if #(
  parameter int IDX_W = 16
);
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] beam_idx;
  logic [31:0]      raw_angle;
  logic [31:0]      reduced_angle;
  logic             flip_y;
  logic             flip_x;
  logic             flip_identity;

  modport master (
    output out_valid, beam_idx, raw_angle, reduced_angle, flip_y, flip_x, flip_identity,
    input  out_ready
  );

  modport slave (
    input  out_valid, beam_idx, raw_angle, reduced_angle, flip_y, flip_x, flip_identity,
    output out_ready
  );
endinterface

// File: rtl/scan_angle_sequencer.sv
// Per-beam angle generator for a laser scan, feeding octant-reduced angles to the ray tracer.
// Optional: define SCAN_ANGLE_STALL_CNT_EN to add the stall_cnt backpressure counter output.

// Folds an angle in [0, 2PI) into [0, PI/4], reporting the mirror operations applied.
module reduce_angle #(
  parameter logic [31:0] PI = 32'h000C90FD
) (
  input  logic [31:0] angle,
  output logic [31:0] reduced,
  output logic        flip_y,
  output logic        flip_x,
  output logic        flip_identity
);
  localparam logic [31:0] TWO_PI     = PI << 1;
  localparam logic [31:0] PI_HALF    = PI >> 1;
  localparam logic [31:0] PI_QUARTER = PI >> 2;

  logic [31:0] a_y;
  logic [31:0] a_x;

  always_comb begin
    flip_y        = (angle >= PI);
    a_y           = flip_y ? (TWO_PI - angle) : angle;
    flip_x        = (a_y >= PI_HALF);
    a_x           = flip_x ? (PI - a_y) : a_y;
    flip_identity = (a_x > PI_QUARTER);
    reduced       = flip_identity ? (PI_HALF - a_x) : a_x;
  end
endmodule

module scan_angle_sequencer #(
  parameter logic [31:0] PI    = 32'h000C90FD,
  parameter int          IDX_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             angle_min,
  input  logic [31:0]             angle_inc,
  input  logic [IDX_W-1:0]        n_beams,
  scan_angle_sequencer_if.master  beam,
  output logic                    busy,
  output logic                    done
`ifdef SCAN_ANGLE_STALL_CNT_EN
  , output logic [31:0]           stall_cnt
`endif
);
  localparam logic [32:0] TWO_PI = {PI, 1'b0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]      min_r;
  logic [31:0]      inc_r;
  logic [IDX_W-1:0] n_r;

  logic             capture;
  logic             load_beam;
  logic             last_accept;
  logic             accept;
  logic             abort_kill;

  logic [31:0]      min_wrapped;
  logic [32:0]      step_sum;
  logic [31:0]      step_wrapped;
  logic [31:0]      next_raw;
  logic [IDX_W-1:0] next_idx;
  logic [31:0]      next_reduced;
  logic             next_flip_y;
  logic             next_flip_x;
  logic             next_flip_identity;

  assign accept     = beam.out_valid && beam.out_ready;
  assign abort_kill = abort && (state != IDLE);
  assign busy       = (state == LOAD) || (state == RUN);
  assign done       = (state == DONE);

  // angle_min may be up to 4PI, so a single subtraction brings it into [0, 2PI).
  assign min_wrapped  = ({1'b0, angle_min} >= TWO_PI) ? 32'({1'b0, angle_min} - TWO_PI)
                                                      : angle_min;
  assign step_sum     = {1'b0, beam.raw_angle} + {1'b0, inc_r};
  assign step_wrapped = (step_sum >= TWO_PI) ? 32'(step_sum - TWO_PI) : step_sum[31:0];
  assign next_raw     = (state == LOAD) ? min_r : step_wrapped;
  assign next_idx     = (state == LOAD) ? '0 : beam.beam_idx + IDX_W'(1);

  reduce_angle #(.PI(PI)) u_reduce (
    .angle         (next_raw),
    .reduced       (next_reduced),
    .flip_y        (next_flip_y),
    .flip_x        (next_flip_x),
    .flip_identity (next_flip_identity)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    load_beam   = 1'b0;
    last_accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          capture    = 1'b1;
          state_next = (n_beams == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          load_beam  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (accept) begin
          if (beam.beam_idx == n_r - IDX_W'(1)) begin
            last_accept = 1'b1;
            state_next  = DONE;
          end else begin
            load_beam = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_r <= '0;
      inc_r <= '0;
      n_r   <= '0;
    end else if (capture) begin
      min_r <= min_wrapped;
      inc_r <= angle_inc;
      n_r   <= n_beams;
    end
  end

  // Output stage only changes on load or on the final accept, so a stalled beam stays frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beam.out_valid     <= 1'b0;
      beam.beam_idx      <= '0;
      beam.raw_angle     <= '0;
      beam.reduced_angle <= '0;
      beam.flip_y        <= 1'b0;
      beam.flip_x        <= 1'b0;
      beam.flip_identity <= 1'b0;
    end else if (abort_kill) begin
      beam.out_valid <= 1'b0;
    end else if (load_beam) begin
      beam.out_valid     <= 1'b1;
      beam.beam_idx      <= next_idx;
      beam.raw_angle     <= next_raw;
      beam.reduced_angle <= next_reduced;
      beam.flip_y        <= next_flip_y;
      beam.flip_x        <= next_flip_x;
      beam.flip_identity <= next_flip_identity;
    end else if (last_accept) begin
      beam.out_valid <= 1'b0;
    end
  end

`ifdef SCAN_ANGLE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (capture) begin
      stall_cnt <= '0;
    end else if (beam.out_valid && !beam.out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_scan_angle_sequencer.sv
// Scoreboard bench for scan_angle_sequencer: directed scans, expected beams queued, monitor compares.
module tb_scan_angle_sequencer;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] angle_min;
  logic [31:0] angle_inc;
  logic [15:0] n_beams;
  logic        busy;
  logic        done;
`ifdef SCAN_ANGLE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  scan_angle_sequencer_if #(.IDX_W(16)) bus ();

  scan_angle_sequencer #(.PI(32'h000C90FD), .IDX_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .angle_min (angle_min),
    .angle_inc (angle_inc),
    .n_beams   (n_beams),
    .beam      (bus.master),
    .busy      (busy),
    .done      (done)
`ifdef SCAN_ANGLE_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic [15:0] idx;
    logic [31:0] raw;
    bit          chk_red;
    logic [31:0] red;
    logic [2:0]  flips;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;
  int   low_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_beam(input logic [15:0] idx, input logic [31:0] raw, input bit chk_red,
                           input logic [31:0] red, input logic [2:0] flips);
    exp_t e;
    e.idx = idx; e.raw = raw; e.chk_red = chk_red; e.red = red; e.flips = flips;
    sb.push_back(e);
  endtask

  // Every valid cycle (stalled or not) must present the head of the queue; pop on accept.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beam: got idx %0d raw 0x%0h expected no beam",
                 bus.beam_idx, bus.raw_angle);
      end else begin
        check_output("beam_idx", 32'(bus.beam_idx), 32'(sb[0].idx));
        check_output("raw_angle", bus.raw_angle, sb[0].raw);
        if (sb[0].chk_red) begin
          check_output("reduced_angle", bus.reduced_angle, sb[0].red);
          check_output("flips_yxi", {29'd0, bus.flip_y, bus.flip_x, bus.flip_identity},
                       {29'd0, sb[0].flips});
        end
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: begin
        if (bus.out_valid) begin
          if (low_cnt < 5) begin
            bus.out_ready = 1'b0;
            low_cnt++;
          end else begin
            bus.out_ready = 1'b1;
            low_cnt = 0;
          end
        end else begin
          bus.out_ready = 1'b0;
          low_cnt = 0;
        end
      end
      default: bus.out_ready = 1'b0;
    endcase
  end

  task automatic apply_stimulus(input logic [31:0] amin, input logic [31:0] ainc, input logic [15:0] n);
    @(posedge clk);
    #1;
    start = 1'b1; angle_min = amin; angle_inc = ainc; n_beams = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int  base;
    bit  seen;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != base) begin
        seen = 1'b1;
        break;
      end
    end
    check_output(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_valid_idx(input logic [15:0] idx, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.beam_idx == idx) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("wait_valid_idx", 32'(seen), 32'd1);
  endtask

  task automatic check_drained(input string name);
    repeat (2) @(negedge clk);
    check_output(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    angle_min = '0; angle_inc = '0; n_beams = '0;
    bus.out_ready = 1'b1;
    #1;
    check_output("reset_valid", 32'(bus.out_valid), 32'd0);
    check_output("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check_output("reset_raw", bus.raw_angle, 32'd0);
    check_output("reset_idx", 32'(bus.beam_idx), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Test 1: four PI/4 steps back to back, with exact cycle alignment.
    ready_mode = 0;
    push_beam(0, 32'h0, 1, 32'h0, 3'b000);
    push_beam(1, 32'h3243F, 0, 0, 0);
    push_beam(2, 32'h6487E, 0, 0, 0);
    push_beam(3, 32'h96CBD, 0, 0, 0);
    apply_stimulus(32'h0, 32'h3243F, 16'd4);
    @(negedge clk);
    check_output("t1_load_valid", 32'(bus.out_valid), 32'd0);
    check_output("t1_load_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_output("t1_first_valid", 32'(bus.out_valid), 32'd1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    check_output("t1_done", 32'(done), 32'd1);
    check_output("t1_done_busy", 32'(busy), 32'd0);
    check_output("t1_done_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check_output("t1_done_pulse_len", 32'(done), 32'd0);
    check_drained("t1_left");

    // Test 2: accumulator wraps past 2PI.
    push_beam(0, 32'h1921F0, 1, 32'hA, 3'b100);
    push_beam(1, 32'h16, 1, 32'h16, 3'b000);
    apply_stimulus(32'h1921F0, 32'h20, 16'd2);
    wait_done("t2_done", 20);
    check_drained("t2_left");

    // Test 3: angle_min at or above 2PI is folded on capture.
    push_beam(0, 32'h10, 1, 32'h10, 3'b000);
    apply_stimulus(32'h19220A, 32'h100, 16'd1);
    wait_done("t3_done", 20);
    check_drained("t3_left");

    // Test 4: five stall cycles on every beam.
    ready_mode = 1;
    push_beam(0, 32'h100, 1, 32'h100, 3'b000);
    push_beam(1, 32'h1100, 1, 32'h1100, 3'b000);
    push_beam(2, 32'h2100, 1, 32'h2100, 3'b000);
    apply_stimulus(32'h100, 32'h1000, 16'd3);
    wait_done("t4_done", 60);
`ifdef SCAN_ANGLE_STALL_CNT_EN
    check_output("t4_stall_cnt", stall_cnt, 32'd15);
`endif
    check_drained("t4_left");
    ready_mode = 0;

    // Test 5: zero beams goes straight to a done pulse.
    apply_stimulus(32'h0, 32'h10, 16'd0);
    @(negedge clk);
    check_output("t5_done", 32'(done), 32'd1);
    check_output("t5_busy_valid", {30'd0, busy, bus.out_valid}, 32'd0);
    @(negedge clk);
    check_output("t5_done_len", 32'(done), 32'd0);
    check_output("t5_after_busy", 32'(busy), 32'd0);

    // Test 6: abort at beam 2, then a clean restart.
    for (int i = 0; i < 8; i++) push_beam(16'(i), 32'(i) << 16, 0, 0, 0);
    apply_stimulus(32'h0, 32'h10000, 16'd8);
    wait_valid_idx(16'd2, 20);
    base = done_cnt;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    sb.delete();
    @(negedge clk);
    check_output("t6_abort_valid", 32'(bus.out_valid), 32'd0);
    check_output("t6_abort_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check_output("t6_no_done", 32'(done_cnt), 32'(base));
    push_beam(0, 32'h0, 1, 32'h0, 3'b000);
    push_beam(1, 32'h10000, 0, 0, 0);
    apply_stimulus(32'h0, 32'h10000, 16'd2);
    wait_done("t6_restart_done", 20);
    check_drained("t6_left");

    // Test 7: octant folding across the identity and both mirror axes.
    push_beam(0, 32'h40000, 1, 32'h2487E, 3'b001);
    push_beam(1, 32'hC91FD, 1, 32'h100, 3'b110);
    apply_stimulus(32'h40000, 32'h891FD, 16'd2);
    wait_done("t7_done", 20);
    check_drained("t7_left");

    // Test 8: asynchronous reset while a beam is stalled.
    ready_mode = 2;
    bus.out_ready = 1'b0;
    push_beam(0, 32'h5000, 1, 32'h5000, 3'b000);
    apply_stimulus(32'h5000, 32'h10, 16'd8);
    wait_valid_idx(16'd0, 20);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check_output("t8_rst_valid", 32'(bus.out_valid), 32'd0);
    check_output("t8_rst_busy", 32'(busy), 32'd0);
    check_output("t8_rst_raw", bus.raw_angle, 32'd0);
    check_output("t8_rst_reduced", bus.reduced_angle, 32'd0);
`ifdef SCAN_ANGLE_STALL_CNT_EN
    check_output("t8_rst_stall", stall_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check_output("t8_idle_after", {30'd0, busy, bus.out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
